// File: rtl/dmem_access_seq.sv
// MEM-stage data-memory sequencer: turns one decoded load/store into a
// req/ack bus transaction, stalls the pipeline while it is outstanding,
// and returns the sign/zero-extended load result.
module dmem_access_seq #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        require_mem_access,
  input  logic        write_to_data_mem,
  input  logic [1:0]  access_size,
  input  logic [2:0]  funct3,
  input  logic        flush,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        resp_valid,
  output logic        misaligned,
  output logic        bus_error
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             req_reg;
  logic             we_reg;
  logic [31:0]      addr_reg;
  logic [3:0]       be_reg;
  logic [31:0]      wdata_reg;
  logic [1:0]       size_reg;
  logic [1:0]       off_reg;
  logic             uns_reg;
  logic             flushed_reg;
  logic [31:0]      load_reg;
  logic             resp_valid_reg;
  logic             misaligned_reg;
  logic             bus_error_reg;

  logic        size_ok;
  logic        aligned;
  logic        attempt;
  logic        start;
  logic        bad_access;
  logic        suppress;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] rdata_shift;
  logic [31:0] load_next;
  logic        unused_funct3;

  // Only funct3[2] (unsigned load) matters here; the rest is decoded upstream.
  assign unused_funct3 = ^funct3[1:0];

  // Alignment / size legality of the incoming access.
  always_comb begin
    aligned = 1'b1;
    case (access_size)
      SZ_WORD: aligned = (addr[1:0] == 2'b00);
      SZ_HALF: aligned = ~addr[0];
      default: aligned = 1'b1;
    endcase
  end

  assign size_ok    = (access_size != 2'b11);
  assign attempt    = (state_reg == ST_IDLE) & require_mem_access & ~flush;
  assign start      = attempt & aligned & size_ok;
  assign bad_access = attempt & ~(aligned & size_ok);
  // A flush seen in any BUSY cycle (including the ack cycle) kills the response.
  assign suppress   = flushed_reg | flush;

  // Per-lane byte enables and replicated write data for the request.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign be_next[gi] = (access_size == SZ_WORD)
                         | ((access_size == SZ_HALF) & (addr[1] == 1'(gi / 2)))
                         | ((access_size == SZ_BYTE) & (addr[1:0] == 2'(gi)));
      assign wdata_next[8*gi +: 8] = (access_size == SZ_WORD) ? store_data[8*gi +: 8] :
                                     (access_size == SZ_HALF) ? store_data[8*(gi % 2) +: 8] :
                                                                store_data[7:0];
    end
  endgenerate

  // Bring the addressed lane down to bit 0, then extend to 32 bits.
  assign rdata_shift = dmem_rdata >> {off_reg, 3'b000};

  always_comb begin
    load_next = 32'd0;
    case (size_reg)
      SZ_WORD: load_next = rdata_shift;
      SZ_HALF: load_next = {{16{rdata_shift[15] & ~uns_reg}}, rdata_shift[15:0]};
      SZ_BYTE: load_next = {{24{rdata_shift[7] & ~uns_reg}}, rdata_shift[7:0]};
      default: load_next = 32'd0;
    endcase
  end

  // Sequencer FSM: captures the request on start, waits for ack or timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      req_reg        <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= 32'd0;
      be_reg         <= 4'd0;
      wdata_reg      <= 32'd0;
      size_reg       <= 2'b00;
      off_reg        <= 2'b00;
      uns_reg        <= 1'b0;
      flushed_reg    <= 1'b0;
      load_reg       <= 32'd0;
      resp_valid_reg <= 1'b0;
      misaligned_reg <= 1'b0;
      bus_error_reg  <= 1'b0;
    end else begin
      resp_valid_reg <= 1'b0;
      misaligned_reg <= 1'b0;
      bus_error_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg   <= ST_BUSY;
            cnt_reg     <= '0;
            req_reg     <= 1'b1;
            we_reg      <= write_to_data_mem;
            addr_reg    <= {addr[31:2], 2'b00};
            be_reg      <= be_next;
            wdata_reg   <= wdata_next;
            size_reg    <= access_size;
            off_reg     <= addr[1:0];
            uns_reg     <= funct3[2];
            flushed_reg <= 1'b0;
          end else if (bad_access) begin
            misaligned_reg <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (flush) flushed_reg <= 1'b1;
          if (dmem_ack) begin
            state_reg      <= ST_RESP;
            req_reg        <= 1'b0;
            we_reg         <= 1'b0;
            load_reg       <= we_reg ? 32'd0 : load_next;
            resp_valid_reg <= ~suppress;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg     <= ST_IDLE;
            req_reg       <= 1'b0;
            we_reg        <= 1'b0;
            bus_error_reg <= ~suppress;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_RESP: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Stall covers the start cycle and every BUSY cycle; released in RESP.
  assign stall = ~rst & (start | (state_reg == ST_BUSY));

  assign dmem_req   = req_reg;
  assign dmem_we    = we_reg;
  assign dmem_addr  = addr_reg;
  assign dmem_be    = be_reg;
  assign dmem_wdata = wdata_reg;
  assign load_data  = load_reg;
  assign resp_valid = resp_valid_reg;
  assign misaligned = misaligned_reg;
  assign bus_error  = bus_error_reg;

endmodule
